// File: rtl/midi_rx_parser_pkg.sv
// midi_pkg: shared MIDI byte constants, byte-class and FSM state enums,
// and helpers used by the receive parser and its byte classifier.
//   byte_class(b)        -> byte_class_e for one received byte
//   chan_data_len(st)    -> number of data bytes (1 or 2) for a channel status
package midi_pkg;

    localparam logic [7:0] MIDI_SYX_START = 8'hF0;
    localparam logic [7:0] MIDI_SYX_END   = 8'hF7;
    localparam logic [7:0] MIDI_RT_MIN    = 8'hF8;

    typedef enum logic [2:0] {
        CLS_CHAN,
        CLS_SYX_START,
        CLS_SYX_END,
        CLS_SYS_COMMON,
        CLS_RT,
        CLS_DATA
    } byte_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPD,
        ST_TRIG
    } parse_state_e;

    function automatic byte_class_e byte_class(input logic [7:0] b);
        byte_class_e c;
        if (!b[7])                  c = CLS_DATA;
        else if (b[7:4] != 4'hF)    c = CLS_CHAN;
        else if (b == MIDI_SYX_START) c = CLS_SYX_START;
        else if (b == MIDI_SYX_END) c = CLS_SYX_END;
        else if (b >= MIDI_RT_MIN)  c = CLS_RT;
        else                        c = CLS_SYS_COMMON;
        return c;
    endfunction

    // Program change (Cx) and channel pressure (Dx) carry one data byte.
    function automatic logic [1:0] chan_data_len(input logic [7:0] st);
        return ((st[7:4] == 4'hC) || (st[7:4] == 4'hD)) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_rx_parser_classify.sv
// midi_byte_classify: combinational MIDI byte classifier.
//   byte_in   in  8  received byte
//   byte_cls  out    byte class (channel / sysex start / sysex end /
//                    system common / real-time / data)
module midi_byte_classify
    import midi_pkg::*;
(
    input  logic [7:0]  byte_in,
    output byte_class_e byte_cls
);

    always_comb begin
        byte_cls = byte_class(byte_in);
    end

endmodule

// File: rtl/midi_rx_parser.sv
// midi_rx_parser: byte-level MIDI input parser feeding the sysex decoder
// and the note/CC handlers. Tracks running status, numbers bytes within a
// message, flags SysEx context, splits off real-time bytes and strobes
// completed channel messages.
//   sys_clk       in   1  system clock
//   reset         in   1  synchronous active-high reset
//   rx_byte       in   8  byte from UART receiver
//   rx_valid      in   1  rx_byte valid strobe
//   databyte      out  8  last non-real-time byte accepted
//   midi_bytes    out  8  index of databyte in current message
//   is_st_sysex   out  1  current message is SysEx (F0..F7)
//   trig_seq      out  1  active-low byte strobe
//   status        out  8  running status (0 = none)
//   midi_ch       out  4  status[3:0]
//   msg_valid     out  1  channel message complete pulse
//   msg_data1     out  7  first data byte of completed message
//   msg_data2     out  7  second data byte (0 for 1-byte messages)
//   rt_valid      out  1  real-time byte pulse
//   rt_byte       out  8  real-time byte
//   syx_overflow  out  1  sticky SysEx length overflow
module midi_rx_parser
    import midi_pkg::*;
#(
    parameter int unsigned TRIG_LOW_CYC = 2,
    parameter int unsigned SYX_MAX      = 255
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] databyte,
    output logic [7:0] midi_bytes,
    output logic       is_st_sysex,
    output logic       trig_seq,
    output logic [7:0] status,
    output logic [3:0] midi_ch,
    output logic       msg_valid,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       syx_overflow
);

    localparam int unsigned CW = (TRIG_LOW_CYC > 1) ? $clog2(TRIG_LOW_CYC) : 1;
    localparam logic [7:0]  SYX_MAX_B = 8'(SYX_MAX);

    parse_state_e state, state_next;
    logic [CW-1:0] trig_cnt;

    logic       skid_full;
    logic [7:0] skid_byte;
    logic [1:0] data_cnt;
    logic [6:0] data1_hold;
    logic       syx_end_pend;

    byte_class_e cls_rx, cls_skid, apply_cls;
    logic [7:0]  apply_byte;
    logic        apply_en, skid_load, skid_clear;
    logic        trig_last, slot_free, eff_syx;
    logic        rx_nrt, rx_ok, skid_ok;

    logic [7:0] mb_inc;
    logic [1:0] cnt_inc;
    logic [1:0] data_len;

    midi_byte_classify u_cls_rx (
        .byte_in  (rx_byte),
        .byte_cls (cls_rx)
    );

    midi_byte_classify u_cls_skid (
        .byte_in  (skid_byte),
        .byte_cls (cls_skid)
    );

    assign midi_ch  = status[3:0];
    assign mb_inc   = (midi_bytes == SYX_MAX_B) ? midi_bytes : midi_bytes + 8'd1;
    assign cnt_inc  = data_cnt + 2'd1;
    assign data_len = chan_data_len(status);

    // Next-state and byte-routing decisions.
    // A terminating F7 keeps is_st_sysex visible through its own strobe, but
    // any byte applied afterwards must already see the SysEx as closed, so
    // decisions use the pending-masked flag.
    always_comb begin
        state_next = state;
        apply_en   = 1'b0;
        apply_byte = rx_byte;
        apply_cls  = cls_rx;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        eff_syx   = is_st_sysex && !syx_end_pend;
        trig_last = (state == ST_TRIG) && (trig_cnt == CW'(TRIG_LOW_CYC - 1));
        slot_free = (state == ST_IDLE) || trig_last;
        rx_nrt    = rx_valid && (cls_rx != CLS_RT);
        rx_ok     = rx_nrt &&
                    !((cls_rx == CLS_DATA) && !eff_syx && (status == 8'h00));
        skid_ok   = skid_full &&
                    !((cls_skid == CLS_DATA) && !eff_syx && (status == 8'h00));

        case (state)
            ST_IDLE: state_next = ST_IDLE;
            ST_UPD:  state_next = ST_TRIG;
            ST_TRIG: state_next = ST_TRIG;
            default: state_next = ST_IDLE;
        endcase

        if (slot_free) begin
            // The held byte takes priority; a byte arriving on the same
            // edge then refills the skid slot. A held byte that turns out to
            // be an orphan data byte is discarded and the new one competes.
            skid_clear = 1'b1;
            state_next = ST_IDLE;
            if (skid_ok) begin
                apply_en   = 1'b1;
                apply_byte = skid_byte;
                apply_cls  = cls_skid;
                skid_load  = rx_nrt;
            end else if (rx_ok) begin
                apply_en   = 1'b1;
            end
            if (apply_en) begin
                state_next = ST_UPD;
            end
        end else begin
            skid_load = rx_nrt && !skid_full;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            trig_cnt <= '0;
            trig_seq <= 1'b1;
        end else begin
            if (state == ST_UPD) begin
                trig_cnt <= '0;
            end else if ((state == ST_TRIG) && !trig_last) begin
                trig_cnt <= trig_cnt + 1'b1;
            end
            trig_seq <= (state_next != ST_TRIG);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            skid_full <= 1'b0;
            skid_byte <= '0;
        end else if (skid_load) begin
            skid_full <= 1'b1;
            skid_byte <= rx_byte;
        end else if (skid_clear) begin
            skid_full <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            databyte     <= '0;
            midi_bytes   <= '0;
            is_st_sysex  <= 1'b0;
            status       <= '0;
            msg_valid    <= 1'b0;
            msg_data1    <= '0;
            msg_data2    <= '0;
            rt_valid     <= 1'b0;
            rt_byte      <= '0;
            syx_overflow <= 1'b0;
            data_cnt     <= '0;
            data1_hold   <= '0;
            syx_end_pend <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            rt_valid  <= 1'b0;

            if (rx_valid && (cls_rx == CLS_RT)) begin
                rt_valid <= 1'b1;
                rt_byte  <= rx_byte;
            end

            if (trig_last && syx_end_pend) begin
                is_st_sysex  <= 1'b0;
                syx_end_pend <= 1'b0;
            end

            if (apply_en) begin
                databyte <= apply_byte;
                case (apply_cls)
                    CLS_CHAN: begin
                        status       <= apply_byte;
                        midi_bytes   <= '0;
                        is_st_sysex  <= 1'b0;
                        syx_end_pend <= 1'b0;
                        data_cnt     <= '0;
                    end
                    CLS_SYX_START: begin
                        is_st_sysex  <= 1'b1;
                        syx_end_pend <= 1'b0;
                        status       <= '0;
                        midi_bytes   <= '0;
                        syx_overflow <= 1'b0;
                    end
                    CLS_SYX_END: begin
                        midi_bytes <= mb_inc;
                        if (eff_syx) begin
                            syx_end_pend <= 1'b1;
                            if (mb_inc == SYX_MAX_B) begin
                                syx_overflow <= 1'b1;
                            end
                        end
                    end
                    CLS_SYS_COMMON: begin
                        status       <= '0;
                        is_st_sysex  <= 1'b0;
                        syx_end_pend <= 1'b0;
                        midi_bytes   <= '0;
                        data_cnt     <= '0;
                    end
                    CLS_DATA: begin
                        if (eff_syx) begin
                            midi_bytes <= mb_inc;
                            if (mb_inc == SYX_MAX_B) begin
                                syx_overflow <= 1'b1;
                            end
                        end else begin
                            midi_bytes <= {6'd0, cnt_inc};
                            if (cnt_inc == 2'd1) begin
                                data1_hold <= apply_byte[6:0];
                            end
                            if (cnt_inc == data_len) begin
                                msg_valid <= 1'b1;
                                msg_data1 <= (data_len == 2'd1) ? apply_byte[6:0] : data1_hold;
                                msg_data2 <= (data_len == 2'd1) ? 7'd0 : apply_byte[6:0];
                                data_cnt  <= '0;
                            end else begin
                                data_cnt  <= cnt_inc;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: directed MIDI sequences with literal
// expectations, then randomized byte traffic compared every cycle against
// a behavioural model of byte acceptance timing and message parsing.
module tb_midi_rx_parser;

    localparam int L    = 2;
    localparam int MAXC = 16000;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] databyte;
    logic [7:0] midi_bytes;
    logic       is_st_sysex;
    logic       trig_seq;
    logic [7:0] status;
    logic [3:0] midi_ch;
    logic       msg_valid;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic       syx_overflow;

    midi_rx_parser #(.TRIG_LOW_CYC(L), .SYX_MAX(255)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .databyte     (databyte),
        .midi_bytes   (midi_bytes),
        .is_st_sysex  (is_st_sysex),
        .trig_seq     (trig_seq),
        .status       (status),
        .midi_ch      (midi_ch),
        .msg_valid    (msg_valid),
        .msg_data1    (msg_data1),
        .msg_data2    (msg_data2),
        .rt_valid     (rt_valid),
        .rt_byte      (rt_byte),
        .syx_overflow (syx_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Expected outputs after each clock edge.
    int e_db[MAXC], e_mb[MAXC], e_syx[MAXC], e_st[MAXC], e_trig[MAXC];
    int e_msg[MAXC], e_d1[MAXC], e_d2[MAXC], e_rt[MAXC], e_rtb[MAXC], e_ovf[MAXC];

    // Model state.
    int m_status, m_cnt, m_mb, m_db, m_d1, m_d2, m_hold, m_rtb, m_ovf;
    bit m_lsyx, m_osyx;
    int clear_at, free_at;
    int skid[$];

    int total = 0;
    int bad   = 0;

    int prev_trig = 1;
    int msg_seen = 0;
    int rt_seen  = 0;
    int fall_mb[$];
    int fall_syx[$];

    task automatic chk(input string n, input logic [31:0] act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic bit drops(input int b);
        return (b < 'h80) && !m_lsyx && (m_status == 0);
    endfunction

    task automatic snapshot(input int e);
        e_db[e] = m_db;   e_mb[e] = m_mb;   e_syx[e] = m_osyx; e_st[e] = m_status;
        e_d1[e] = m_d1;   e_d2[e] = m_d2;   e_rtb[e] = m_rtb;  e_ovf[e] = m_ovf;
    endtask

    task automatic apply(input int e, input int b);
        int len;
        free_at = e + L + 1;
        for (int k = e + 1; k <= e + L && k < MAXC; k++) e_trig[k] = 0;
        m_db = b;
        if (b >= 'h80 && b <= 'hEF) begin
            m_status = b; m_mb = 0; m_lsyx = 0; m_osyx = 0; m_cnt = 0; clear_at = -1;
        end else if (b == 'hF0) begin
            m_lsyx = 1; m_osyx = 1; m_status = 0; m_mb = 0; m_ovf = 0; clear_at = -1;
        end else if (b == 'hF7) begin
            m_mb = sat(m_mb);
            if (m_lsyx) begin
                if (m_mb == 255) m_ovf = 1;
                m_lsyx   = 0;
                clear_at = e + L + 1;
            end
        end else if (b >= 'hF1 && b <= 'hF6) begin
            m_status = 0; m_lsyx = 0; m_osyx = 0; m_mb = 0; m_cnt = 0; clear_at = -1;
        end else begin
            if (m_lsyx) begin
                m_mb = sat(m_mb);
                if (m_mb == 255) m_ovf = 1;
            end else begin
                len = ((m_status >> 4) == 'hC || (m_status >> 4) == 'hD) ? 1 : 2;
                m_cnt++;
                m_mb = m_cnt;
                if (m_cnt == 1) m_hold = b;
                if (m_cnt == len) begin
                    e_msg[e] = 1;
                    m_d1 = (len == 1) ? b : m_hold;
                    m_d2 = (len == 1) ? 0 : b;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic model_step(input int e, input bit v, input int b, input bit rst);
        bit nrt, applied;
        int sb;
        if (e >= MAXC) return;
        e_msg[e] = 0;
        e_rt[e]  = 0;
        if (rst) begin
            m_status = 0; m_cnt = 0; m_mb = 0; m_db = 0; m_d1 = 0; m_d2 = 0;
            m_hold = 0; m_rtb = 0; m_ovf = 0; m_lsyx = 0; m_osyx = 0;
            clear_at = -1; free_at = e + 1;
            skid.delete();
            for (int k = e; k <= e + L && k < MAXC; k++) e_trig[k] = 1;
            snapshot(e);
            return;
        end
        if (e == clear_at) m_osyx = 0;
        if (v && b >= 'hF8) begin
            m_rtb = b;
            e_rt[e] = 1;
        end
        nrt = v && (b < 'hF8);
        if (e >= free_at) begin
            applied = 0;
            if (skid.size() > 0) begin
                sb = skid.pop_front();
                if (!drops(sb)) begin
                    apply(e, sb);
                    applied = 1;
                    if (nrt) skid.push_back(b);
                end
            end
            if (!applied && nrt && !drops(b)) apply(e, b);
        end else if (nrt && skid.size() == 0) begin
            skid.push_back(b);
        end
        snapshot(e);
    endtask

    task automatic compare_now();
        if (cyc >= 1 && cyc < MAXC) begin
            chk("databyte",     databyte,     e_db[cyc]);
            chk("midi_bytes",   midi_bytes,   e_mb[cyc]);
            chk("is_st_sysex",  is_st_sysex,  e_syx[cyc]);
            chk("trig_seq",     trig_seq,     e_trig[cyc]);
            chk("status",       status,       e_st[cyc]);
            chk("midi_ch",      midi_ch,      e_st[cyc] & 15);
            chk("msg_valid",    msg_valid,    e_msg[cyc]);
            chk("msg_data1",    msg_data1,    e_d1[cyc]);
            chk("msg_data2",    msg_data2,    e_d2[cyc]);
            chk("rt_valid",     rt_valid,     e_rt[cyc]);
            chk("rt_byte",      rt_byte,      e_rtb[cyc]);
            chk("syx_overflow", syx_overflow, e_ovf[cyc]);
        end
        if (prev_trig == 1 && trig_seq == 1'b0) begin
            fall_mb.push_back(int'(midi_bytes));
            fall_syx.push_back(int'(is_st_sysex));
        end
        prev_trig = int'(trig_seq);
        if (msg_valid) msg_seen++;
        if (rt_valid)  rt_seen++;
    endtask

    task automatic step(input bit v, input int b, input bit rst);
        @(negedge sys_clk);
        compare_now();
        reset    = rst;
        rx_valid = v;
        rx_byte  = 8'(b);
        model_step(cyc + 1, v, b, rst);
    endtask

    task automatic send(input int b);
        step(1'b1, b, 1'b0);
        repeat (L + 4) step(1'b0, 0, 1'b0);
    endtask

    task automatic clear_obs();
        fall_mb.delete();
        fall_syx.delete();
        msg_seen = 0;
        rt_seen  = 0;
    endtask

    function automatic int qpack(input int q[$]);
        int v = 0;
        for (int i = 0; i < q.size() && i < 4; i++) v |= (q[i] & 255) << (8 * i);
        return v;
    endfunction

    function automatic int qsum(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    function automatic int rand_byte();
        int k = $urandom_range(0, 99);
        if (k < 55) return $urandom_range(0, 127);
        if (k < 70) return $urandom_range('h80, 'hEF);
        if (k < 75) return 'hF0;
        if (k < 82) return 'hF7;
        if (k < 86) return $urandom_range('hF1, 'hF6);
        return $urandom_range('hF8, 'hFF);
    endfunction

    initial begin
        for (int k = 0; k < MAXC; k++) e_trig[k] = 1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        model_step(1, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("rst_trig",   trig_seq,     1);
        chk("rst_status", status,       0);
        chk("rst_db",     databyte,     0);
        chk("rst_ovf",    syx_overflow, 0);

        // Note on, then running status.
        clear_obs();
        send('h90); send('h3C); send('h64);
        chk("t1_falls",  fall_mb.size(), 3);
        chk("t1_mbseq",  qpack(fall_mb), 'h020100);
        chk("t1_msgs",   msg_seen, 1);
        chk("t1_d1",     msg_data1, 'h3C);
        chk("t1_d2",     msg_data2, 'h64);
        chk("t1_ch",     midi_ch, 0);

        clear_obs();
        send('h3C); send('h00);
        chk("t2_mbseq",  qpack(fall_mb), 'h0201);
        chk("t2_msgs",   msg_seen, 1);
        chk("t2_d1",     msg_data1, 'h3C);
        chk("t2_d2",     msg_data2, 'h00);
        chk("t2_status", status, 'h90);

        // One-data-byte message.
        clear_obs();
        send('hC5); send('h07);
        chk("t3_msgs",   msg_seen, 1);
        chk("t3_d1",     msg_data1, 'h07);
        chk("t3_d2",     msg_data2, 0);
        chk("t3_ch",     midi_ch, 5);
        chk("t3_mbseq",  qpack(fall_mb), 'h0100);

        // SysEx framing.
        clear_obs();
        send('hF0); send('h7D); send('h75); send('h12); send('hF7);
        chk("t4_falls",  fall_mb.size(), 5);
        chk("t4_mbseq",  qpack(fall_mb), 'h03020100);
        if (fall_mb.size() == 5) chk("t4_mblast", fall_mb[4], 4);
        chk("t4_syx",    qsum(fall_syx), 5);
        chk("t4_msgs",   msg_seen, 0);
        chk("t4_syxend", is_st_sysex, 0);

        // Real-time byte inside SysEx.
        clear_obs();
        send('hF0); send('h7D); send('hF8); send('h12); send('hF7);
        chk("t5_rt",     rt_seen, 1);
        chk("t5_rtb",    rt_byte, 'hF8);
        chk("t5_falls",  fall_mb.size(), 4);
        chk("t5_mbseq",  qpack(fall_mb), 'h03020100);

        // Back-to-back bytes: one held, third dropped.
        clear_obs();
        step(1'b1, 'h90, 1'b0); step(1'b1, 'h3C, 1'b0); step(1'b1, 'h64, 1'b0);
        repeat (2 * L + 6) step(1'b0, 0, 1'b0);
        chk("skid_falls", fall_mb.size(), 2);
        chk("skid_mbseq", qpack(fall_mb), 'h0100);
        chk("skid_msgs",  msg_seen, 0);
        chk("skid_db",    databyte, 'h3C);

        // SysEx length saturation.
        clear_obs();
        send('hF0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, $urandom_range(0, 127), 1'b0);
            repeat (L) step(1'b0, 0, 1'b0);
        end
        repeat (L + 2) step(1'b0, 0, 1'b0);
        chk("t6_mb",  midi_bytes, 255);
        chk("t6_ovf", syx_overflow, 1);

        // Reset in the middle of traffic.
        step(1'b1, 'h11, 1'b0);
        step(1'b1, 'h22, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("mr_db",   databyte, 0);
        chk("mr_mb",   midi_bytes, 0);
        chk("mr_syx",  is_st_sysex, 0);
        chk("mr_trig", trig_seq, 1);
        chk("mr_ovf",  syx_overflow, 0);
        chk("mr_d1",   msg_data1, 0);
        chk("mr_rtb",  rt_byte, 0);
        clear_obs();
        send('h80); send('h40); send('h00);
        chk("mr_msgs",   msg_seen, 1);
        chk("mr_n_d1",   msg_data1, 'h40);
        chk("mr_n_d2",   msg_data2, 0);
        chk("mr_status", status, 'h80);

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                step(1'b0, 0, 1'b1);
            end else if ($urandom_range(0, 99) < 45) begin
                step(1'b1, rand_byte(), 1'b0);
            end else begin
                step(1'b0, 0, 1'b0);
            end
        end
        repeat (10) step(1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
